fifo_ctrl_8x32: RTL

8-entry x 32-bit FIFO storage and control stage. Sits directly upstream of the 8-to-1 read mux: it holds the eight entry registers and drives the head pointer as the mux select, so the mux output is always the oldest entry. It provides write/read handshakes, full/empty flags and an occupancy count to the top level.

---
 rtl/fifo_pkg.sv | 18 +
 rtl/fifo_ns_cal.sv | 41 ++++
 rtl/fifo_ctrl_8x32.sv | 119 +++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and FSM encoding for the 8x32 FIFO control stage.
package fifo_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int DEPTH      = 8;
    localparam int ADDR_WIDTH = 3;
    localparam int CNT_WIDTH  = ADDR_WIDTH + 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WRITE  = 3'd1,
        READ   = 3'd2,
        RW     = 3'd3,
        WR_ERR = 3'd4,
        RD_ERR = 3'd5
    } state_t;

endpackage

// File: rtl/fifo_ns_cal.sv
// Next-state / next-count calculation: decides which requests are accepted
// from the current occupancy and classifies the edge into an FSM state.
module fifo_ns_cal
    import fifo_pkg::*;
(
    input  logic                 wr_en,
    input  logic                 rd_en,
    input  logic [CNT_WIDTH-1:0] count,
    output state_t               next_state,
    output logic [CNT_WIDTH-1:0] next_count,
    output logic                 push_ok,
    output logic                 pop_ok
);

    logic is_full;
    logic is_empty;

    assign is_full  = (count == CNT_WIDTH'(DEPTH));
    assign is_empty = (count == '0);

    // Acceptance, next occupancy and state classification for this edge.
    // A rejected request takes priority over a lone accepted one so that
    // mixed cases (full+both, empty+both) report the error state.
    always_comb begin
        push_ok    = wr_en && !is_full;
        pop_ok     = rd_en && !is_empty;
        next_count = count + CNT_WIDTH'(push_ok) - CNT_WIDTH'(pop_ok);
        next_state = IDLE;
        if (push_ok && pop_ok)
            next_state = RW;
        else if (wr_en && !push_ok)
            next_state = WR_ERR;
        else if (rd_en && !pop_ok)
            next_state = RD_ERR;
        else if (push_ok)
            next_state = WRITE;
        else if (pop_ok)
            next_state = READ;
    end

endmodule

// File: rtl/fifo_ctrl_8x32.sv
// 8-entry x 32-bit FIFO storage and control. Holds the entry registers and
// presents the head pointer as the downstream read-mux select.
module fifo_ctrl_8x32
    import fifo_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] from_reg0,
    output logic [DATA_WIDTH-1:0] from_reg1,
    output logic [DATA_WIDTH-1:0] from_reg2,
    output logic [DATA_WIDTH-1:0] from_reg3,
    output logic [DATA_WIDTH-1:0] from_reg4,
    output logic [DATA_WIDTH-1:0] from_reg5,
    output logic [DATA_WIDTH-1:0] from_reg6,
    output logic [DATA_WIDTH-1:0] from_reg7,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [CNT_WIDTH-1:0]  data_count,
    output logic                  full,
    output logic                  empty,
    output logic                  wr_ack,
    output logic                  wr_err,
    output logic                  rd_ack,
    output logic                  rd_err,
    output logic [2:0]            state
);

    logic [DEPTH-1:0][DATA_WIDTH-1:0] entry_q;
    logic [ADDR_WIDTH-1:0]            head_q;
    logic [ADDR_WIDTH-1:0]            tail_q;
    logic [CNT_WIDTH-1:0]             count_q;
    logic [CNT_WIDTH-1:0]             count_d;
    state_t                           state_q;
    state_t                           state_d;
    logic                             push_ok;
    logic                             pop_ok;

    fifo_ns_cal u_ns_cal (
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .count      (count_q),
        .next_state (state_d),
        .next_count (count_d),
        .push_ok    (push_ok),
        .pop_ok     (pop_ok)
    );

    // State register; next state comes from fifo_ns_cal.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Entry registers: only the slot addressed by tail is written on a push.
    // Popped entries are left intact.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            entry_q <= '0;
        end else if (push_ok) begin
            for (int i = 0; i < DEPTH; i++)
                if (tail_q == ADDR_WIDTH'(i))
                    entry_q[i] <= din;
        end
    end

    // Head/tail pointers; 3-bit width gives the mod-8 wrap for free.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            if (pop_ok)  head_q <= head_q + 1'b1;
            if (push_ok) tail_q <= tail_q + 1'b1;
        end
    end

    // Occupancy and flags, all taken from the next count so they agree.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
            full    <= 1'b0;
            empty   <= 1'b1;
        end else begin
            count_q <= count_d;
            full    <= (count_d == CNT_WIDTH'(DEPTH));
            empty   <= (count_d == '0);
        end
    end

    // Handshake pulses describing the most recent edge only.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ack <= 1'b0;
            wr_err <= 1'b0;
            rd_ack <= 1'b0;
            rd_err <= 1'b0;
        end else begin
            wr_ack <= push_ok;
            wr_err <= wr_en && !push_ok;
            rd_ack <= pop_ok;
            rd_err <= rd_en && !pop_ok;
        end
    end

    assign from_reg0  = entry_q[0];
    assign from_reg1  = entry_q[1];
    assign from_reg2  = entry_q[2];
    assign from_reg3  = entry_q[3];
    assign from_reg4  = entry_q[4];
    assign from_reg5  = entry_q[5];
    assign from_reg6  = entry_q[6];
    assign from_reg7  = entry_q[7];
    assign rd_addr    = head_q;
    assign data_count = count_q;
    assign state      = state_q;

endmodule
